// File: rtl/tff_counter.sv
// Up/down modulo counter built from T flip-flops: q <= q ^ t, with t derived from q and its next value.
// Optional macro TFF_COUNTER_TOGGLE_OUT_EN adds the registered toggle-mask output tgl.
module tff_counter #(
   parameter int WIDTH = 4,
   parameter int MOD   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             up,
   input  logic             sat,
   output logic [WIDTH-1:0] q,
`ifdef TFF_COUNTER_TOGGLE_OUT_EN
   output logic [WIDTH-1:0] tgl,
`endif
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

   if ((MOD < 2) || (longint'(MOD) > (longint'(1) << WIDTH))) begin : g_bad_mod
      $error("tff_counter: MOD=%0d illegal for WIDTH=%0d", MOD, WIDTH);
   end

   logic [WIDTH-1:0] r_q;
   logic             r_tc;
   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_t;
   logic             w_tc;

   always_comb begin
      w_next = r_q;
      w_tc   = 1'b0;
      if (load) begin
         w_next = (d > MAXV) ? MAXV : d;
      end else if (en) begin
         if (up) begin
            if (r_q == MAXV) begin
               w_tc   = 1'b1;
               w_next = sat ? r_q : '0;
            end else begin
               w_next = r_q + 1'b1;
            end
         end else begin
            if (r_q == '0) begin
               w_tc   = 1'b1;
               w_next = sat ? r_q : MAXV;
            end else begin
               w_next = r_q - 1'b1;
            end
         end
      end
      // Toggle mask: only bits that differ from the next count flip.
      w_t = w_next ^ r_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q  <= '0;
         r_tc <= 1'b0;
      end else begin
         r_q  <= r_q ^ w_t;
         r_tc <= w_tc;
      end
   end

   assign q  = r_q;
   assign tc = r_tc;

`ifdef TFF_COUNTER_TOGGLE_OUT_EN
   logic [WIDTH-1:0] r_tgl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_tgl <= '0;
      else        r_tgl <= w_t;
   end

   assign tgl = r_tgl;
`endif

endmodule

// File: tb/tb_tff_counter.sv
// Scoreboard bench for tff_counter: u0 is WIDTH=4/MOD=10, u1 is WIDTH=4/MOD=16.
module tb_tff_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en0 = 1'b0, load0 = 1'b0, en1 = 1'b0, load1 = 1'b0;
   logic [3:0] d = '0;
   logic       up = 1'b1, sat = 1'b0;
   logic [3:0] q0, q1;
   logic       tc0, tc1;
`ifdef TFF_COUNTER_TOGGLE_OUT_EN
   logic [3:0] tgl0, tgl1;
`endif

   always #5 clk = ~clk;

   tff_counter #(.WIDTH(4), .MOD(10)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en0), .load(load0), .d(d), .up(up), .sat(sat),
      .q(q0),
`ifdef TFF_COUNTER_TOGGLE_OUT_EN
      .tgl(tgl0),
`endif
      .tc(tc0));

   tff_counter #(.WIDTH(4), .MOD(16)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en1), .load(load1), .d(d), .up(up), .sat(sat),
      .q(q1),
`ifdef TFF_COUNTER_TOGGLE_OUT_EN
      .tgl(tgl1),
`endif
      .tc(tc1));

   typedef struct {
      int         id;
      bit         sel;
      logic [3:0] q;
      logic       tc;
      logic [3:0] tgl;
      bit         ctgl;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   id = 0;
   event chk_ev;

   task automatic push(bit s, logic [3:0] eq, logic et, logic [3:0] eg, bit ct);
      exp_t e;
      e.id = id; e.sel = s; e.q = eq; e.tc = et; e.tgl = eg; e.ctgl = ct;
      sb.push_back(e);
      id++;
   endtask

   // Drive one edge's inputs on the negedge, then queue what the next sample must show.
   task automatic step(bit s, bit e, bit l, logic [3:0] dv, bit u, bit sa,
                       logic [3:0] eq, logic et, logic [3:0] eg, bit ct);
      @(negedge clk);
      en0 = !s && e; load0 = !s && l;
      en1 = s && e;  load1 = s && l;
      d = dv; up = u; sat = sa;
      @(posedge clk);
      #1 push(s, eq, et, eg, ct);
   endtask

   // Monitor: compares queued expectations against the DUT between edges.
   initial begin
      forever begin
         @(negedge clk or chk_ev);
         while (sb.size() > 0) begin
            exp_t e;
            logic [3:0] aq, ag;
            logic at;
            e = sb.pop_front();
            aq = e.sel ? q1 : q0;
            at = e.sel ? tc1 : tc0;
            ag = '0;
`ifdef TFF_COUNTER_TOGGLE_OUT_EN
            ag = e.sel ? tgl1 : tgl0;
`endif
            checks++;
            if (aq !== e.q) begin
               errors++;
               $display("FAIL item%0d u%0d q got %0d exp %0d", e.id, e.sel, aq, e.q);
            end
            checks++;
            if (at !== e.tc) begin
               errors++;
               $display("FAIL item%0d u%0d tc got %0b exp %0b", e.id, e.sel, at, e.tc);
            end
`ifdef TFF_COUNTER_TOGGLE_OUT_EN
            if (e.ctgl) begin
               checks++;
               if (ag !== e.tgl) begin
                  errors++;
                  $display("FAIL item%0d u%0d tgl got %b exp %b", e.id, e.sel, ag, e.tgl);
               end
            end
`endif
         end
      end
   end

   initial begin
      // Reset state of both counters.
      #2 push(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
      push(1'b1, 4'd0, 1'b0, 4'd0, 1'b1);
      ->chk_ev;
      @(negedge clk) rst_n = 1'b1;

      // Count to 6, then assert reset between edges.
      for (int i = 1; i <= 6; i++)
         step(0, 1, 0, 4'd0, 1, 0, 4'(i), 1'b0, 4'd0, 0);
      @(negedge clk) en0 = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 push(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
      ->chk_ev;
      @(negedge clk) rst_n = 1'b1;
      step(0, 1, 0, 4'd0, 1, 0, 4'd1, 1'b0, 4'd0, 0);

      // Up wrap.
      step(0, 0, 1, 4'd8, 1, 0, 4'd8, 1'b0, 4'd0, 0);
      step(0, 1, 0, 4'd0, 1, 0, 4'd9, 1'b0, 4'd0, 0);
      step(0, 1, 0, 4'd0, 1, 0, 4'd0, 1'b1, 4'd0, 0);
      step(0, 1, 0, 4'd0, 1, 0, 4'd1, 1'b0, 4'd0, 0);

      // Down saturate.
      step(0, 0, 1, 4'd2, 0, 1, 4'd2, 1'b0, 4'd0, 0);
      step(0, 1, 0, 4'd0, 0, 1, 4'd1, 1'b0, 4'd0, 0);
      step(0, 1, 0, 4'd0, 0, 1, 4'd0, 1'b0, 4'd0, 0);
      step(0, 1, 0, 4'd0, 0, 1, 4'd0, 1'b1, 4'd0, 0);
      step(0, 1, 0, 4'd0, 0, 1, 4'd0, 1'b1, 4'd0, 0);

      // Down wrap from 0 to MOD-1.
      step(0, 1, 0, 4'd0, 0, 0, 4'd9, 1'b1, 4'd0, 0);

      // Load clamp with priority over en, then wrap.
      step(0, 1, 1, 4'd13, 1, 0, 4'd9, 1'b0, 4'd0, 0);
      step(0, 1, 0, 4'd0, 1, 0, 4'd0, 1'b1, 4'd0, 0);

      // Hold while up/sat wiggle.
      step(0, 0, 1, 4'd5, 1, 0, 4'd5, 1'b0, 4'd0, 0);
      for (int i = 0; i < 5; i++)
         step(0, 0, 0, 4'd3, i[0], i[1], 4'd5, 1'b0, 4'd0, 0);

      // Natural binary roll-over on the full-range counter and toggle mask.
      step(1, 0, 1, 4'd15, 1, 0, 4'd15, 1'b0, 4'b1111, 1);
      step(1, 1, 0, 4'd0, 1, 0, 4'd0, 1'b1, 4'b1111, 1);
      step(1, 1, 0, 4'd0, 1, 0, 4'd1, 1'b0, 4'b0001, 1);
      step(1, 0, 0, 4'd0, 1, 0, 4'd1, 1'b0, 4'b0000, 1);

      @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending got %0d exp 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
